// File: rtl/gru_serial_top.sv
// ============================================================================
//  Module      : gru_serial_top (with gru_core)
//  Description : FPGA top-level for a GRU sequence equalizer. Loads a 3x3
//                float sequence over a bit-serial link, starts gru_core on a
//                button press and shifts the 32-bit result back out serially.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

// Integration stand-in for the GRU datapath: fixed latency that scales with
// the unit count, result is the XOR fold of all input words.
module gru_core #(
    parameter int DATA_WIDTH      = 32,
    parameter int INPUT_FEATURES  = 3,
    parameter int SEQUENCE_LENGTH = 3,
    parameter int GRU_UNITS       = 3
) (
    input  logic                                                   clk,
    input  logic                                                   rstn,
    input  logic                                                   start_i,
    input  logic [DATA_WIDTH*INPUT_FEATURES*SEQUENCE_LENGTH-1:0]   x_flat_i,
    output logic                                                   done_o,
    output logic [DATA_WIDTH-1:0]                                  result_o
);
    localparam int N       = INPUT_FEATURES * SEQUENCE_LENGTH;
    localparam int LATENCY = 32 * GRU_UNITS + 4;
    localparam int CNT_W   = $clog2(LATENCY + 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] fold;

    // Reduce the whole sequence to one word
    always_comb begin
        fold = '0;
        for (int i = 0; i < N; i++) begin
            fold = fold ^ x_flat_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Latency counter and one-cycle done pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
            end else if (busy_q) begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    busy_q   <= 1'b0;
                    done_o   <= 1'b1;
                    result_o <= fold;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end
endmodule

module gru_serial_top #(
    parameter int DATA_WIDTH      = 32,
    parameter int INPUT_FEATURES  = 3,
    parameter int SEQUENCE_LENGTH = 3,
    parameter int GRU_UNITS       = 3,
    parameter int SER_HALF        = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_start,
    input  logic       serial_data_in,
    input  logic       serial_clk_in,
    input  logic       serial_load_en,
    output logic       serial_data_out,
    output logic       serial_clk_out,
    output logic       serial_valid,
    output logic       led_done,
    output logic       led_ready,
    output logic       led_loading,
    output logic [3:0] led_state
);
    localparam int N    = INPUT_FEATURES * SEQUENCE_LENGTH;
    localparam int WC_W = $clog2(N + 1);
    localparam int BC_W = $clog2(DATA_WIDTH);
    localparam int PH_W = $clog2(2 * SER_HALF);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IDLE     = 4'd1,
        S_LOADING  = 4'd2,
        S_READY    = 4'd3,
        S_COMPUTE  = 4'd4,
        S_TRANSMIT = 4'd5,
        S_DONE     = 4'd6
    } state_t;

    state_t state_q, state_d;

    logic [2:0] btn_sync_q, sclk_sync_q, load_sync_q;
    logic [1:0] data_sync_q;
    logic       btn_rise, sclk_rise, load_rise, load_fall, data_s;

    logic [DATA_WIDTH-2:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [BC_W-1:0]       rx_bit_q;
    logic [WC_W-1:0]       word_cnt_q;
    logic [DATA_WIDTH-1:0] buf_q [N];

    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [BC_W-1:0]       tx_bit_q;
    logic [PH_W-1:0]       ph_cnt_q;
    logic                  ph_end, tx_last;
    logic                  led_done_q;

    logic                      core_start, core_done;
    logic [DATA_WIDTH-1:0]     core_result;
    logic [DATA_WIDTH*N-1:0]   core_x;

    // Two-flop synchronisers; the third stage on strobes gives edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            btn_sync_q  <= '0;
            sclk_sync_q <= '0;
            load_sync_q <= '0;
            data_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[1:0], btn_start};
            sclk_sync_q <= {sclk_sync_q[1:0], serial_clk_in};
            load_sync_q <= {load_sync_q[1:0], serial_load_en};
            data_sync_q <= {data_sync_q[0], serial_data_in};
        end
    end

    assign btn_rise  = btn_sync_q[1] & ~btn_sync_q[2];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign load_rise = load_sync_q[1] & ~load_sync_q[2];
    assign load_fall = ~load_sync_q[1] & load_sync_q[2];
    assign data_s    = data_sync_q[1];
    assign rx_word   = {rx_sh_q, data_s};

    assign ph_end  = (ph_cnt_q == PH_W'(2 * SER_HALF - 1));
    assign tx_last = ph_end && (tx_bit_q == BC_W'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // Next-state logic and the core start strobe
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        case (state_q)
            S_INIT:     state_d = S_IDLE;
            S_IDLE:     if (load_rise) state_d = S_LOADING;
            S_LOADING:  if (load_fall) state_d = (word_cnt_q == WC_W'(N)) ? S_READY : S_IDLE;
            S_READY: begin
                if (load_rise) begin
                    state_d = S_LOADING;
                end else if (btn_rise) begin
                    state_d    = S_COMPUTE;
                    core_start = 1'b1;
                end
            end
            S_COMPUTE:  if (core_done) state_d = S_TRANSMIT;
            S_TRANSMIT: if (tx_last) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_INIT;
        endcase
    end

    // Receive shifter, word buffer, transmit shifter and done flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            word_cnt_q <= '0;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            ph_cnt_q   <= '0;
            led_done_q <= 1'b0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else begin
            if ((state_q == S_IDLE || state_q == S_READY) && load_rise) begin
                word_cnt_q <= '0;
                rx_bit_q   <= '0;
                led_done_q <= 1'b0;
            end else if (state_q == S_LOADING) begin
                if (load_fall) begin
                    // A partially received word is dropped here
                    rx_bit_q <= '0;
                end else if (sclk_rise) begin
                    rx_sh_q <= rx_word[DATA_WIDTH-2:0];
                    if (rx_bit_q == BC_W'(DATA_WIDTH - 1)) begin
                        rx_bit_q <= '0;
                        if (word_cnt_q < WC_W'(N)) begin
                            for (int i = 0; i < N; i++) begin
                                if (word_cnt_q == WC_W'(i)) buf_q[i] <= rx_word;
                            end
                            word_cnt_q <= word_cnt_q + WC_W'(1);
                        end
                    end else begin
                        rx_bit_q <= rx_bit_q + BC_W'(1);
                    end
                end
            end

            if (state_q == S_COMPUTE && core_done) begin
                tx_sh_q  <= core_result;
                tx_bit_q <= '0;
                ph_cnt_q <= '0;
            end else if (state_q == S_TRANSMIT) begin
                if (ph_end) begin
                    ph_cnt_q <= '0;
                    tx_sh_q  <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    tx_bit_q <= tx_bit_q + BC_W'(1);
                    if (tx_last) led_done_q <= 1'b1;
                end else begin
                    ph_cnt_q <= ph_cnt_q + PH_W'(1);
                end
            end
        end
    end

    // Word 0 lands in the least significant slice of the core bus
    generate
        for (genvar g = 0; g < N; g++) begin : g_flat
            assign core_x[g*DATA_WIDTH +: DATA_WIDTH] = buf_q[g];
        end
    endgenerate

    gru_core #(
        .DATA_WIDTH      (DATA_WIDTH),
        .INPUT_FEATURES  (INPUT_FEATURES),
        .SEQUENCE_LENGTH (SEQUENCE_LENGTH),
        .GRU_UNITS       (GRU_UNITS)
    ) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (core_start),
        .x_flat_i (core_x),
        .done_o   (core_done),
        .result_o (core_result)
    );

    assign led_state       = state_q;
    assign led_ready       = (state_q == S_READY);
    assign led_loading     = (state_q == S_LOADING);
    assign led_done        = led_done_q;
    assign serial_valid    = (state_q == S_TRANSMIT);
    assign serial_clk_out  = serial_valid && (ph_cnt_q >= PH_W'(SER_HALF));
    assign serial_data_out = serial_valid && tx_sh_q[DATA_WIDTH-1];
endmodule

`default_nettype wire

// File: tb/tb_gru_serial_top.sv
// ============================================================================
//  Module      : tb_gru_serial_top
//  Description : Directed self-checking bench for gru_serial_top.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gru_serial_top;
    localparam int SER_HALF = 4;
    localparam int N        = 9;

    logic       clk = 1'b0;
    logic       rstn, btn_start, sdi, sci, sle;
    logic       serial_data_out, serial_clk_out, serial_valid;
    logic       led_done, led_ready, led_loading;
    logic [3:0] led_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int start_cnt = 0;
    logic [31:0] words [N];

    gru_serial_top #(.SER_HALF(SER_HALF)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .btn_start       (btn_start),
        .serial_data_in  (sdi),
        .serial_clk_in   (sci),
        .serial_load_en  (sle),
        .serial_data_out (serial_data_out),
        .serial_clk_out  (serial_clk_out),
        .serial_valid    (serial_valid),
        .led_done        (led_done),
        .led_ready       (led_ready),
        .led_loading     (led_loading),
        .led_state       (led_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.core_start) start_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] fold_model();
        logic [31:0] f = 32'h0;
        for (int i = 0; i < N; i++) f = f ^ words[i];
        return f;
    endfunction

    task automatic send_word(input logic [31:0] w);
        for (int b = 31; b >= 0; b--) begin
            sdi = w[b];
            sci = 1'b1;
            tick();
            sci = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
    endtask

    task automatic load_words(input int n);
        sle = 1'b1;
        repeat (4) tick();
        check("load_state", {28'd0, led_state}, 32'd2);
        check("led_loading", {31'd0, led_loading}, 32'd1);
        for (int w = 0; w < n; w++) send_word(words[w]);
        sle = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int max, input string tag);
        int k = 0;
        while (led_state !== s && k < max) begin
            tick();
            k++;
        end
        check(tag, {28'd0, led_state}, {28'd0, s});
    endtask

    task automatic press_button(input int cycles);
        btn_start = 1'b1;
        repeat (cycles) tick();
        btn_start = 1'b0;
    endtask

    // Capture serial_data_out on rising edges of serial_clk_out
    task automatic rx_result(input int stop_edges, output logic [31:0] val,
                             output int edges, output int lat, output bit valid_ok);
        int   k = 0;
        logic prev = 1'b0;
        val = 32'h0; edges = 0; lat = -1; valid_ok = 1'b1;
        while (!serial_valid && k < 400) begin
            tick();
            k++;
        end
        check("valid_rise", {31'd0, serial_valid}, 32'd1);
        check("tx_state", {28'd0, led_state}, 32'd5);
        k = 0;
        while (k < 400) begin
            if (!serial_valid) valid_ok = 1'b0;
            if (serial_clk_out && !prev) begin
                val = {val[30:0], serial_data_out};
                if (edges == 0) lat = k;
                edges++;
            end
            prev = serial_clk_out;
            if (edges >= stop_edges) break;
            tick();
            k++;
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!led_done && k < 12) begin
            tick();
            k++;
        end
        check(tag, {31'd0, led_done}, 32'd1);
    endtask

    initial begin
        logic [31:0] val;
        int          edges, lat, s0;
        bit          vok;

        rstn = 1'b0; btn_start = 1'b0; sdi = 1'b0; sci = 1'b0; sle = 1'b0;

        // Reset behaviour
        repeat (5) tick();
        check("reset_outputs",
              {22'd0, serial_data_out, serial_clk_out, serial_valid, led_done,
               led_ready, led_loading, led_state}, 32'd0);
        repeat (15) tick();
        rstn = 1'b1;
        #1;
        check("state_init", {28'd0, led_state}, 32'd0);
        tick();
        check("state_idle", {28'd0, led_state}, 32'd1);
        check("ready_after_reset", {31'd0, led_ready}, 32'd0);

        // Full load of 9 words
        words[0] = 32'h3F800000; words[1] = 32'h40000000; words[2] = 32'h40400000;
        words[3] = 32'hBF800000; words[4] = 32'h3F000000; words[5] = 32'h40800000;
        words[6] = 32'hC0000000; words[7] = 32'h3E800000; words[8] = 32'h0;
        words[8] = 32'h3F800000 ^ fold_model();
        load_words(9);
        wait_state(4'd3, 5, "ready_after_load");
        check("led_ready", {31'd0, led_ready}, 32'd1);
        for (int i = 0; i < N; i++) check($sformatf("buf%0d", i), dut.core_x[i*32 +: 32], words[i]);

        // Partial load from READY falls back to IDLE; start is ignored
        load_words(5);
        wait_state(4'd1, 5, "idle_partial");
        check("ready_partial", {31'd0, led_ready}, 32'd0);
        s0 = start_cnt;
        press_button(2);
        repeat (6) tick();
        check("idle_after_btn", {28'd0, led_state}, 32'd1);
        check("no_start_idle", start_cnt - s0, 32'd0);

        // Full run with a held button
        load_words(9);
        wait_state(4'd3, 5, "ready_run1");
        s0 = start_cnt;
        press_button(5);
        check("compute_state", {28'd0, led_state}, 32'd4);
        check("one_start", start_cnt - s0, 32'd1);
        rx_result(32, val, edges, lat, vok);
        check("result_run1", val, 32'h3F800000);
        check("edges_run1", edges, 32'd32);
        check("first_edge_lat", lat, SER_HALF);
        check("valid_held", {31'd0, vok}, 32'd1);
        wait_done("done_run1");
        wait_state(4'd1, 3, "idle_after_run1");
        check("one_start_after", start_cnt - s0, 32'd1);

        // Reset in the middle of transmission
        words[0] = 32'h12345678; words[1] = 32'hA5A5A5A5; words[2] = 32'h0F0F0000;
        words[3] = 32'h00C0FFEE; words[4] = 32'h80000001; words[5] = 32'h7F7FFFFF;
        words[6] = 32'h41200000; words[7] = 32'hDEADBEEF; words[8] = 32'h00000100;
        load_words(9);
        wait_state(4'd3, 5, "ready_run2");
        press_button(2);
        rx_result(10, val, edges, lat, vok);
        check("edges_before_rst", edges, 32'd10);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", {31'd0, serial_valid}, 32'd0);
        check("rst_clk_out", {31'd0, serial_clk_out}, 32'd0);
        check("rst_state", {28'd0, led_state}, 32'd0);
        check("rst_done", {31'd0, led_done}, 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        wait_state(4'd1, 3, "idle_after_rst");

        // A full run after reset completes with the folded result
        load_words(9);
        wait_state(4'd3, 5, "ready_run3");
        press_button(2);
        rx_result(32, val, edges, lat, vok);
        check("result_run3", val, fold_model());
        check("edges_run3", edges, 32'd32);
        check("valid_held_run3", {31'd0, vok}, 32'd1);
        wait_done("done_run3");
        wait_state(4'd1, 3, "idle_after_run3");

        // A new load window clears led_done
        sle = 1'b1;
        repeat (4) tick();
        check("done_cleared", {31'd0, led_done}, 32'd0);
        check("load_after_done", {28'd0, led_state}, 32'd2);
        sle = 1'b0;
        wait_state(4'd1, 5, "idle_empty_load");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/gru_serial_top.md
Name: gru_serial_top

Overview:
- FPGA top-level wrapper for a GRU sequence equalizer.
- Receives a 3-timestep × 3-feature IEEE-754 single-precision input sequence over a slow bit-serial link, then runs a GRU inference core when the start button is pressed.
- Returns the 32-bit float prediction over a bit-serial output link and reports progress on LEDs.
- The GRU arithmetic lives in the instantiated submodule gru_core. This block is control, buffering and serial I/O only.

Parameters:
- DATA_WIDTH, 32: word width (IEEE-754 single).
- INPUT_FEATURES, 3: features per timestep.
- SEQUENCE_LENGTH, 3: timesteps per sequence. Total words N = 9.
- GRU_UNITS, 3: hidden units; passed through to gru_core.
- SER_HALF, 4: clk cycles per half-period of serial_clk_out.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- btn_start  in  1  start button, level; asynchronous to clk.
- serial_data_in  in  1  serial input data, MSB first.
- serial_clk_in  in  1  serial input clock; data sampled on its rising edge.
- serial_load_en  in  1  load window enable, level.
- serial_data_out  out  1  serial result data, MSB first.
- serial_clk_out  out  1  serial output clock; data stable at its rising edge.
- serial_valid  out  1  high for the whole result transmission.
- led_done  out  1  result sent; sticky.
- led_ready  out  1  full sequence loaded (state 3).
- led_loading  out  1  load in progress (state 2).
- led_state  out  4  current FSM state code.

Behaviour:
- Input synchronisation:
  - btn_start, serial_data_in, serial_clk_in and serial_load_en each pass through 2-flop synchronisers.
  - Rising edges of the synchronised btn_start and serial_clk_in are detected with one extra register.
- FSM codes on led_state:
  - 0 INIT: entered on reset; lasts exactly 1 cycle, then IDLE.
  - 1 IDLE: buffer empty or invalid.
  - 2 LOADING.
  - 3 READY.
  - 4 COMPUTE.
  - 5 TRANSMIT.
  - 6 DONE: lasts 1 cycle, then IDLE.
  - Codes 7–15 are unused; any such state returns to INIT.
- IDLE or READY, synchronised serial_load_en rising edge:
  - go to LOADING; clear word counter and bit counter; clear led_done.
- LOADING:
  - Each serial_clk_in rising edge shifts the synchronised data bit into a 32-bit register, MSB first.
  - The 32nd bit writes the word to buffer[word_cnt] (index = t*INPUT_FEATURES + f) and increments word_cnt.
  - Words beyond 9 are ignored.
  - When serial_load_en falls: go to READY if word_cnt == 9, else IDLE. Any partial word is discarded.
- Serial clock edges outside LOADING are ignored.
- READY, btn_start rising edge:
  - go to COMPUTE and issue a 1-cycle gru_start pulse to gru_core.
  - gru_core receives the buffer as a 288-bit flattened bus, word 0 in bits [31:0].
- btn_start edges in any other state are ignored. A held button never retriggers.
- COMPUTE:
  - wait for the gru_core 1-cycle done pulse; latch its 32-bit result into the TX shift register.
  - go to TRANSMIT.
  - No timeout.
- TRANSMIT:
  - serial_valid = 1 from the first cycle.
  - For each of the 32 bits, MSB first: drive serial_data_out, hold serial_clk_out low for SER_HALF cycles, then high for SER_HALF cycles.
  - Data changes only while serial_clk_out is low.
  - First rising edge of serial_clk_out comes SER_HALF cycles after serial_valid rises.
  - After the 32nd high phase: serial_clk_out = 0, serial_valid = 0, led_done = 1, go to DONE.
- led_done stays 1 until the next load starts or reset.
- led_ready = (state == 3). led_loading = (state == 2).
- The input buffer is retained after a run, but state returns to IDLE. A reload is required before the next start.
- Reset (synchronous, any state, including mid-load or mid-transmit):
  - state INIT.
  - counters 0; buffer and shift registers 0.
  - all outputs 0: serial_data_out, serial_clk_out, serial_valid, led_done, led_ready, led_loading, led_state = 0.
  - gru_core receives the same rstn.
- load_en rising edge during COMPUTE or TRANSMIT is ignored.

Test Plan:
1. Hold rstn low 20 cycles, release -> all outputs 0 during reset; led_state 0 for 1 cycle, then 1; led_ready = 0, led_done = 0.
2. Load 9 words (bit: data + clk_in high 1 cycle, low 2 cycles, idle 1; 10 idle cycles between words), then deassert load_en -> led_state 2 with led_loading = 1 during load; led_state 3 with led_ready = 1 within 5 cycles of deassert; buffer[0..8] equals the sent words.
3. Load only 5 words, then deassert load_en -> led_state 1, led_ready = 0. Then pulse btn_start -> state stays 1 and gru_core sees no start.
4. From READY, hold btn_start high 5 cycles with a core stub returning 0x3F800000 after 100 cycles -> exactly one gru_start pulse; state 4, then 5.
   - Capturing serial_data_out on 32 serial_clk_out rising edges gives 0x3F800000 (1.0).
   - serial_valid is high throughout.
   - led_done = 1 within 5 cycles of the last edge; state returns to 1.
5. Assert rstn low mid-transmit, at bit 10 -> next cycle serial_valid = 0, serial_clk_out = 0, led_state = 0.
   - A subsequent full load + start completes normally.
   - The next load_en rise clears led_done.
6. End-to-end with the real gru_core and 8 golden sequences run back-to-back -> each received float is within 0.01 absolute of its golden output; every run ends in state 1 with led_done = 1.
